// File: rtl/bram_job_scheduler.sv
// Job scheduler: queues accessor run requests and launches them one at a time; muxes BRAM0 host/accessor.
// Latency: a job pushed into an idle, empty, unblocked scheduler produces acc_start_o one cycle after the push.
// Backpressure: job_ready_o low while the queue is full; host waits for S_IDLE, jobs wait while host holds BRAM0.
module bram_job_scheduler #(
   parameter int CNT_BIT = 31,
   parameter int AWIDTH  = 8,
   parameter int DWIDTH  = 32,
   parameter int QDEPTH  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               job_valid_i,
   input  logic [CNT_BIT-1:0] job_count_i,
   output logic               job_ready_o,
   input  logic               host_req_i,
   input  logic [AWIDTH-1:0]  host_addr_i,
   input  logic               host_we_i,
   input  logic [DWIDTH-1:0]  host_d_i,
   output logic               host_gnt_o,
   output logic               acc_start_o,
   output logic [CNT_BIT-1:0] acc_count_o,
   input  logic               acc_idle_i,
   input  logic               acc_done_i,
   input  logic [AWIDTH-1:0]  acc_addr_b0_i,
   input  logic               acc_ce_b0_i,
   input  logic               acc_we_b0_i,
   output logic [AWIDTH-1:0]  addr_b0_o,
   output logic               ce_b0_o,
   output logic               we_b0_o,
   output logic [DWIDTH-1:0]  d_b0_o,
   output logic               busy_o,
   output logic [7:0]         jobs_done_o,
   output logic               err_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam int PW = $clog2(QDEPTH);
   // Largest count the accessor can address: one pass over the whole BRAM.
   localparam logic [CNT_BIT-1:0] MAX_CNT = CNT_BIT'(64'd1 << AWIDTH);

   logic [1:0]         state_q, state_d;
   logic [CNT_BIT-1:0] q_mem_q [QDEPTH];
   logic [PW:0]        wr_ptr_q, wr_ptr_d;
   logic [PW:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_BIT-1:0] count_q, count_d;
   logic [7:0]         jobs_done_q, jobs_done_d;
   logic               err_q, err_d;
   logic               q_empty, q_full, push, pop;
   logic [CNT_BIT-1:0] q_head;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign q_empty = (wr_ptr_q == rd_ptr_q);
   assign q_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign q_head  = q_mem_q[rd_ptr_q[PW-1:0]];
   assign push    = job_valid_i && !q_full;

   // Next-state logic: pop/launch from idle, count sanitising, completion counting.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      jobs_done_d = jobs_done_q;
      err_d       = err_q;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Host holds BRAM0 while requesting, so launching is deferred.
            if (!q_empty && !host_req_i) begin
               pop = 1'b1;
               if (q_head == '0) begin
                  // Zero-length job is dropped without a start pulse.
                  err_d = 1'b1;
               end else if (q_head > MAX_CNT) begin
                  err_d   = 1'b1;
                  count_d = MAX_CNT;
                  state_d = S_START;
               end else begin
                  count_d = q_head;
                  state_d = S_START;
               end
            end
         end
         S_START: state_d = S_RUN;
         S_RUN: begin
            if (acc_done_i) begin
               jobs_done_d = jobs_done_q + 8'd1;
               state_d     = S_DRAIN;
            end
         end
         default: begin
            if (acc_idle_i) state_d = S_IDLE;
         end
      endcase
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   // Control registers with synchronous reset; a reset drops all queued jobs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         jobs_done_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         jobs_done_q <= jobs_done_d;
         err_q       <= err_d;
      end
   end

   // Queue storage; contents are meaningless while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push) q_mem_q[wr_ptr_q[PW-1:0]] <= job_count_i;
   end

   // Host owns BRAM0 only from idle; otherwise the accessor drives it directly.
   always_comb begin
      host_gnt_o = (state_q == S_IDLE) && host_req_i;
      if (host_gnt_o) begin
         addr_b0_o = host_addr_i;
         ce_b0_o   = host_req_i;
         we_b0_o   = host_we_i;
         d_b0_o    = host_d_i;
      end else begin
         addr_b0_o = acc_addr_b0_i;
         ce_b0_o   = acc_ce_b0_i;
         we_b0_o   = acc_we_b0_i;
         d_b0_o    = '0;
      end
   end

   assign job_ready_o = !q_full;
   assign acc_start_o = (state_q == S_START);
   assign acc_count_o = count_q;
   assign busy_o      = (state_q != S_IDLE) || !q_empty;
   assign jobs_done_o = jobs_done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_bram_job_scheduler.sv
// Randomized bench for bram_job_scheduler against a transaction-queue reference model.
// A behavioural accessor answers each start pulse after a random run time.
// Outputs are compared every cycle on the falling clock edge.
module tb_bram_job_scheduler;
   localparam int CNT_BIT = 31;
   localparam int AWIDTH  = 8;
   localparam int DWIDTH  = 32;
   localparam int QDEPTH  = 4;
   localparam int NCYC    = 4000;

   logic               clk = 1'b0;
   logic               reset;
   logic               job_valid_i;
   logic [CNT_BIT-1:0] job_count_i;
   logic               job_ready_o;
   logic               host_req_i;
   logic [AWIDTH-1:0]  host_addr_i;
   logic               host_we_i;
   logic [DWIDTH-1:0]  host_d_i;
   logic               host_gnt_o;
   logic               acc_start_o;
   logic [CNT_BIT-1:0] acc_count_o;
   logic               acc_idle_i;
   logic               acc_done_i;
   logic [AWIDTH-1:0]  acc_addr_b0_i;
   logic               acc_ce_b0_i;
   logic               acc_we_b0_i;
   logic [AWIDTH-1:0]  addr_b0_o;
   logic               ce_b0_o;
   logic               we_b0_o;
   logic [DWIDTH-1:0]  d_b0_o;
   logic               busy_o;
   logic [7:0]         jobs_done_o;
   logic               err_o;

   bram_job_scheduler #(.CNT_BIT(CNT_BIT), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .reset(reset),
      .job_valid_i(job_valid_i), .job_count_i(job_count_i), .job_ready_o(job_ready_o),
      .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_we_i(host_we_i),
      .host_d_i(host_d_i), .host_gnt_o(host_gnt_o),
      .acc_start_o(acc_start_o), .acc_count_o(acc_count_o),
      .acc_idle_i(acc_idle_i), .acc_done_i(acc_done_i),
      .acc_addr_b0_i(acc_addr_b0_i), .acc_ce_b0_i(acc_ce_b0_i), .acc_we_b0_i(acc_we_b0_i),
      .addr_b0_o(addr_b0_o), .ce_b0_o(ce_b0_o), .we_b0_o(we_b0_o), .d_b0_o(d_b0_o),
      .busy_o(busy_o), .jobs_done_o(jobs_done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: spec-level job phases and a queue of pending counts.
   typedef enum int {P_IDLE, P_START, P_RUN, P_DRAIN} phase_e;
   phase_e  m_ph;
   longint  m_q[$];
   longint  m_cnt;
   int      m_jobs;
   bit      m_err;

   // Behavioural accessor.
   bit a_busy;
   int a_left;
   int a_wait;
   bit a_done_idle;

   function automatic logic [CNT_BIT-1:0] pick_count();
      case ($urandom_range(0, 9))
         0:       return '0;
         1:       return CNT_BIT'(300);
         2:       return CNT_BIT'(256);
         3:       return CNT_BIT'(257);
         4:       return CNT_BIT'($urandom);
         default: return CNT_BIT'($urandom_range(1, 8));
      endcase
   endfunction

   task automatic model_reset();
      m_ph = P_IDLE;
      m_q.delete();
      m_cnt  = 0;
      m_jobs = 0;
      m_err  = 1'b0;
      a_busy = 1'b0;
      a_left = 0;
      a_wait = 0;
   endtask

   task automatic check_outputs();
      bit gnt;
      gnt = (m_ph == P_IDLE) && host_req_i;
      chk("acc_start", acc_start_o, m_ph == P_START);
      chk("acc_count", acc_count_o, m_cnt);
      chk("job_ready", job_ready_o, m_q.size() < QDEPTH);
      chk("host_gnt",  host_gnt_o, gnt);
      chk("busy",      busy_o, (m_ph != P_IDLE) || (m_q.size() != 0));
      chk("jobs_done", jobs_done_o, m_jobs);
      chk("err",       err_o, m_err);
      chk("ce_b0",     ce_b0_o, gnt ? 1'b1 : acc_ce_b0_i);
      chk("addr_b0",   addr_b0_o, gnt ? host_addr_i : acc_addr_b0_i);
      chk("we_b0",     we_b0_o, gnt ? host_we_i : acc_we_b0_i);
      chk("d_b0",      d_b0_o, gnt ? host_d_i : 0);
   endtask

   // Advance model and accessor across the coming clock edge.
   task automatic model_step();
      bit     push;
      longint c;
      if (reset) begin
         model_reset();
         return;
      end
      push = job_valid_i && (m_q.size() < QDEPTH);
      // Accessor bookkeeping uses the values it drove this cycle.
      if (a_busy) begin
         if (a_left == 0) begin
            a_busy = 1'b0;
            a_wait = a_done_idle ? 0 : $urandom_range(1, 2);
         end else begin
            a_left--;
         end
      end else if (a_wait > 0) begin
         a_wait--;
      end
      if (m_ph == P_START) begin
         a_busy      = 1'b1;
         a_left      = $urandom_range(0, 5);
         a_done_idle = $urandom_range(0, 1) != 0;
      end
      case (m_ph)
         P_IDLE: begin
            if (m_q.size() != 0 && !host_req_i) begin
               c = m_q.pop_front();
               if (c == 0) m_err = 1'b1;
               else begin
                  if (c > (1 << AWIDTH)) begin
                     c = 1 << AWIDTH;
                     m_err = 1'b1;
                  end
                  m_cnt = c;
                  m_ph  = P_START;
               end
            end
         end
         P_START: m_ph = P_RUN;
         P_RUN: if (acc_done_i) begin
            m_jobs = (m_jobs + 1) % 256;
            m_ph   = P_DRAIN;
         end
         P_DRAIN: if (acc_idle_i) m_ph = P_IDLE;
      endcase
      if (push) m_q.push_back(longint'(job_count_i));
   endtask

   initial begin
      int vld_pct;
      int host_pct;
      reset         = 1'b1;
      job_valid_i   = 1'b0;
      job_count_i   = '0;
      host_req_i    = 1'b0;
      host_addr_i   = '0;
      host_we_i     = 1'b0;
      host_d_i      = '0;
      acc_idle_i    = 1'b1;
      acc_done_i    = 1'b0;
      acc_addr_b0_i = '0;
      acc_ce_b0_i   = 1'b0;
      acc_we_b0_i   = 1'b0;
      model_reset();
      vld_pct  = 50;
      host_pct = 10;
      repeat (2) @(posedge clk);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         // Vary traffic mix so queue-full, host-blocking and idle stretches all occur.
         if (cyc % 400 == 0) begin
            vld_pct  = $urandom_range(5, 90);
            host_pct = $urandom_range(0, 30);
         end
         reset = (cyc < 3) || ($urandom_range(0, 299) == 0);
         job_valid_i = $urandom_range(0, 99) < vld_pct;
         job_count_i = pick_count();
         // Host requests come in short bursts.
         if ($urandom_range(0, 99) < host_pct) host_req_i = ~host_req_i;
         host_addr_i   = AWIDTH'($urandom);
         host_we_i     = $urandom_range(0, 1) != 0;
         host_d_i      = DWIDTH'($urandom);
         acc_addr_b0_i = AWIDTH'($urandom);
         acc_ce_b0_i   = a_busy && ($urandom_range(0, 3) != 0);
         acc_we_b0_i   = $urandom_range(0, 1) != 0;
         acc_done_i    = a_busy && (a_left == 0);
         acc_idle_i    = a_busy ? (acc_done_i && a_done_idle) : (a_wait == 0);
         #1;
         if (cyc > 0) check_outputs();
         model_step();
      end
      @(negedge clk);
      check_outputs();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bram_job_scheduler.md
# bram_job_scheduler

Job scheduler for the BRAM accumulate datapath. It queues run requests (element counts) from the controller and launches them one at a time on the BRAM accessor through its start/count handshake. It also shares the single BRAM0 port between the host loader and the accessor, so input data can be written between jobs. It sits between the register/controller logic and the accessor, and owns BRAM0 port muxing.

## Interface
Parameters:
- CNT_BIT, 31, width of a job count.
- AWIDTH, 8, BRAM0 address width; maximum legal count is 2^AWIDTH.
- DWIDTH, 32, BRAM0 data width.
- QDEPTH, 4, job queue depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- job_valid_i  in  1  controller offers a job.
- job_count_i  in  CNT_BIT  element count of the offered job.
- job_ready_o  out  1  queue not full; high when not full, independent of job_valid_i.
- host_req_i  in  1  host loader requests BRAM0.
- host_addr_i / host_we_i / host_d_i  in  AWIDTH / 1 / DWIDTH  host BRAM0 access.
- host_gnt_o  out  1  host owns BRAM0 this cycle.
- acc_start_o  out  1  one-cycle start pulse to the accessor.
- acc_count_o  out  CNT_BIT  count for the current job; held stable from start until done.
- acc_idle_i / acc_done_i  in  1  accessor state outputs.
- acc_addr_b0_i / acc_ce_b0_i / acc_we_b0_i  in  AWIDTH / 1 / 1  accessor BRAM0 request.
- addr_b0_o / ce_b0_o / we_b0_o / d_b0_o  out  AWIDTH / 1 / 1 / DWIDTH  to BRAM0.
- busy_o  out  1  state is not S_IDLE, or the queue is non-empty.
- jobs_done_o  out  8  completed-job counter; wraps from 255 to 0.
- err_o  out  1  sticky; cleared only by reset.

## Operation
Job queue:
- FIFO of QDEPTH entries.
- A push occurs on a clock edge where job_valid_i and job_ready_o are both high.
- Entries are popped only on the S_IDLE to S_START transition.
- A push into a full queue cannot occur, because job_ready_o is low when full.
- A push and a pop on the same edge are both performed; the queue occupancy is unchanged.

FSM states: S_IDLE, S_START, S_RUN, S_DRAIN.
- S_IDLE to S_START:
  - Condition: the queue is non-empty and host_req_i is 0.
  - Action: pop the head entry into the acc_count_o register.
- S_START to S_RUN: unconditional. acc_start_o is 1 only while in S_START.
- S_RUN to S_DRAIN:
  - Condition: acc_done_i is 1.
  - Action: increment jobs_done_o.
- S_DRAIN to S_IDLE: when acc_idle_i is 1.

Count rules, applied at pop:
- Count 0: the entry is discarded, err_o is set, and the FSM stays in S_IDLE. No start pulse is issued.
- Count greater than 2^AWIDTH: clamped to 2^AWIDTH, err_o is set, and the job runs.

BRAM0 arbitration:
- host_gnt_o = (state is S_IDLE) AND host_req_i. This is combinational.
- The host has priority over pending jobs, but only while in S_IDLE. A host request raised mid-job waits until the FSM returns to S_IDLE.
- When host_gnt_o is 1: addr, ce and we come from the host port and d_b0_o = host_d_i. The ce asserted on BRAM0 is host_req_i.
- Otherwise: addr, ce and we are forwarded from the accessor, and d_b0_o = 0.
- ce_b0_o is 0 whenever neither side is active.

## Timing
- Reset values:
  - state: S_IDLE; queue: empty.
  - acc_start_o = 0; acc_count_o = 0.
  - jobs_done_o = 0; err_o = 0; busy_o = 0.
  - job_ready_o = 1; host_gnt_o = 0.
- Reset asserted mid-job:
  - All of the above take their reset values on the next edge.
  - Queued jobs are lost.
  - The accessor is reset by its own reset.
- Launch latency: push sampled at edge E0; S_START entered at edge E1; acc_start_o is high during the cycle after E1. This is 1 cycle after the push when idle and not blocked.
- Back-to-back jobs: the minimum gap between start pulses is the accessor run time + 1 (S_DRAIN) + 1 (S_IDLE) + 1 (S_START).
- acc_done_i arriving in S_START is ignored; only S_RUN reacts to it.
- acc_done_i and acc_idle_i high together in S_RUN: go to S_DRAIN; S_DRAIN exits on the following edge.

## Test plan
- Single job: push count 4 into an idle, empty queue → acc_start_o high 1 cycle after the push with acc_count_o = 4; the FSM returns to S_IDLE after acc_done_i and then acc_idle_i; jobs_done_o = 1.
- Queue fill: push 4 jobs (1, 2, 3, 4) while the accessor is busy → job_ready_o drops to 0 after the 4th push; jobs launch in order 1, 2, 3, 4; jobs_done_o = 4.
- Host priority: host_req_i held for 3 cycles while in S_IDLE with a job queued → host_gnt_o = 1 for those 3 cycles with BRAM0 driven by host_addr_i; acc_start_o asserts 1 cycle after host_req_i falls.
- Host blocked mid-job: host_req_i rises in S_RUN → host_gnt_o stays 0 and BRAM0 follows accessor signals until S_IDLE.
- Errors: push count 0 → no start pulse and err_o = 1. Push count 300 with AWIDTH 8 → acc_count_o = 256 and err_o = 1.
- Reset in S_RUN with 2 jobs queued → next cycle: S_IDLE, queue empty, job_ready_o = 1, jobs_done_o = 0, no further start pulses.
